// File: rtl/edge_event_arbiter.sv
// edge_event_arbiter: synchronizes level inputs, detects qualified edges and
// hands them out one at a time through a round-robin valid/ready channel.
module edge_event_arbiter #(
    parameter int N     = 4,
    parameter int CNT_W = 8,
    parameter int ID_W  = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [N-1:0]     in_lvl,
    input  logic [N-1:0]     cfg_rise_en,
    input  logic [N-1:0]     cfg_fall_en,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [ID_W-1:0]  evt_id,
    output logic             evt_rise,
    output logic [N-1:0]     ovf_flag,
    output logic [CNT_W-1:0] ovf_cnt,
    input  logic             ovf_clr
);

    typedef enum logic {IDLE, PRESENT} state_t;

    localparam int SW = CNT_W + 5;

    state_t          state, state_nxt;
    logic [N-1:0]    s1, s2, s3;
    logic [N-1:0]    rise, fall, qual, store, drop, gnt;
    logic [N-1:0]    pend, pend_rise, pend_nxt, pend_rise_nxt;
    logic [N-1:0]    ovf_flag_nxt;
    logic [CNT_W-1:0] ovf_cnt_nxt, cnt_base;
    logic [SW-1:0]   cnt_sum;
    logic [4:0]      drop_cnt;
    logic [ID_W-1:0] last_grant, gnt_id, idx;
    logic            gnt_en;

    assign rise  = s2 & ~s3 & cfg_rise_en;
    assign fall  = ~s2 & s3 & cfg_fall_en;
    assign qual  = rise | fall;
    assign gnt   = gnt_en ? (N'(1) << gnt_id) : '0;
    assign drop  = qual & pend & ~gnt;
    assign store = qual & ~drop;

    // two-flop synchronizer followed by a history flop for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1 <= '0;
            s2 <= '0;
            s3 <= '0;
        end else begin
            s1 <= in_lvl;
            s2 <= s1;
            s3 <= s2;
        end
    end

    // round-robin search for the first pending channel after last_grant
    always_comb begin
        gnt_en = 1'b0;
        gnt_id = '0;
        idx    = '0;
        for (int k = 1; k <= N; k++) begin
            idx = ID_W'((int'(last_grant) + k) % N);
            if (state == IDLE && !gnt_en && pend[idx]) begin
                gnt_en = 1'b1;
                gnt_id = idx;
            end
        end
    end

    // pending slot update and saturating overflow accounting; a drop beats a clear
    always_comb begin
        pend_nxt      = (pend & ~gnt) | qual;
        pend_rise_nxt = (pend_rise & ~store) | (rise & store);
        drop_cnt      = '0;
        for (int i = 0; i < N; i++) drop_cnt = drop_cnt + 5'(drop[i]);
        cnt_base      = ovf_clr ? '0 : ovf_cnt;
        cnt_sum       = SW'(cnt_base) + SW'(drop_cnt);
        ovf_cnt_nxt   = (cnt_sum > SW'({CNT_W{1'b1}})) ? '1 : cnt_sum[CNT_W-1:0];
        ovf_flag_nxt  = (ovf_clr ? '0 : ovf_flag) | drop;
    end

    // FSM state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // FSM next state: grant from IDLE, hold the event in PRESENT until accepted
    always_comb begin
        state_nxt = state;
        evt_valid = (state == PRESENT);
        if (state == IDLE && gnt_en)            state_nxt = PRESENT;
        else if (state == PRESENT && evt_ready) state_nxt = IDLE;
    end

    // pending slots, presented event and overflow registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend       <= '0;
            pend_rise  <= '0;
            evt_id     <= '0;
            evt_rise   <= 1'b0;
            last_grant <= ID_W'(N - 1);
            ovf_flag   <= '0;
            ovf_cnt    <= '0;
        end else begin
            pend      <= pend_nxt;
            pend_rise <= pend_rise_nxt;
            ovf_flag  <= ovf_flag_nxt;
            ovf_cnt   <= ovf_cnt_nxt;
            if (gnt_en) begin
                evt_id     <= gnt_id;
                evt_rise   <= pend_rise[gnt_id];
                last_grant <= gnt_id;
            end
        end
    end

endmodule

// File: tb/tb_edge_event_arbiter.sv
// tb_edge_event_arbiter: directed scoreboard bench for edge_event_arbiter.
module tb_edge_event_arbiter;

    localparam int N = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [3:0] in_lvl, rise_en, fall_en;
    logic       evt_valid, evt_ready, evt_rise, ovf_clr;
    logic [1:0] evt_id;
    logic [3:0] ovf_flag;
    logic [7:0] ovf_cnt;

    int         tests = 0;
    int         fails = 0;
    logic [2:0] sb[$];
    logic [1:0] ord[3] = '{2'd0, 2'd1, 2'd3};

    edge_event_arbiter #(.N(N), .CNT_W(8)) dut (
        .clk(clk), .rst_n(rst_n), .in_lvl(in_lvl),
        .cfg_rise_en(rise_en), .cfg_fall_en(fall_en),
        .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_id(evt_id), .evt_rise(evt_rise),
        .ovf_flag(ovf_flag), .ovf_cnt(ovf_cnt), .ovf_clr(ovf_clr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // scoreboard: every accepted event must match the oldest expected one
    always @(negedge clk) begin
        logic [2:0] e;
        if (rst_n && evt_valid && evt_ready) begin
            tests++;
            assert (sb.size() != 0) else begin
                fails++;
                $error("FAIL evt_extra got id=%0d rise=%0d exp=no event", evt_id, evt_rise);
            end
            if (sb.size() != 0) begin
                e = sb.pop_front();
                chk("evt_id", 32'(evt_id), 32'(e[2:1]));
                chk("evt_rise", 32'(evt_rise), 32'(e[0]));
            end
        end
    end

    initial begin
        rst_n = 1'b0; in_lvl = '0; rise_en = 4'hF; fall_en = '0;
        evt_ready = 1'b1; ovf_clr = 1'b0;
        step(3);
        chk("rst_valid", 32'(evt_valid), 0);
        chk("rst_id", 32'(evt_id), 0);
        chk("rst_rise", 32'(evt_rise), 0);
        chk("rst_flag", 32'(ovf_flag), 0);
        chk("rst_cnt", 32'(ovf_cnt), 0);
        rst_n = 1'b1;
        step(2);
        // single rise on channel 2: valid appears after the third edge, one cycle wide
        sb.push_back({2'd2, 1'b1});
        in_lvl = 4'b0100;
        step(3);
        chk("lat_early", 32'(evt_valid), 0);
        step(1);
        chk("lat_valid", 32'(evt_valid), 1);
        chk("lat_id", 32'(evt_id), 2);
        chk("lat_rise", 32'(evt_rise), 1);
        step(1);
        chk("lat_single", 32'(evt_valid), 0);
        in_lvl = '0;
        step(6);
        chk("t1_drained", 32'(sb.size()), 0);
        // simultaneous rises on 0, 1, 3 after reset: round-robin order, one per 2 cycles
        rst_n = 1'b0;
        step(1);
        rst_n = 1'b1;
        step(1);
        sb.push_back({2'd0, 1'b1});
        sb.push_back({2'd1, 1'b1});
        sb.push_back({2'd3, 1'b1});
        in_lvl = 4'b1011;
        step(3);
        chk("rr_early", 32'(evt_valid), 0);
        for (int k = 0; k < 5; k++) begin
            step(1);
            chk("rr_valid", 32'(evt_valid), 32'((k % 2) == 0));
            if ((k % 2) == 0) chk("rr_id", 32'(evt_id), 32'(ord[k / 2]));
        end
        in_lvl = '0;
        step(6);
        chk("t2_drained", 32'(sb.size()), 0);
        // backpressure while channel 1 toggles three times
        fall_en = 4'hF;
        step(2);
        evt_ready = 1'b0;
        sb.push_back({2'd1, 1'b1});
        sb.push_back({2'd1, 1'b0});
        in_lvl = 4'b0010;
        step(3);
        in_lvl = 4'b0000;
        step(3);
        in_lvl = 4'b0010;
        for (int k = 0; k < 6; k++) begin
            step(1);
            chk("hold_valid", 32'(evt_valid), 1);
            chk("hold_id", 32'(evt_id), 1);
            chk("hold_rise", 32'(evt_rise), 1);
        end
        chk("bp_flag", 32'(ovf_flag), 32'h2);
        chk("bp_cnt", 32'(ovf_cnt), 1);
        evt_ready = 1'b1;
        step(6);
        chk("t3_drained", 32'(sb.size()), 0);
        // overflow saturation with all channels toggling every cycle
        evt_ready = 1'b0;
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("clr_cnt", 32'(ovf_cnt), 0);
        repeat (80) begin
            in_lvl = ~in_lvl;
            step(1);
        end
        step(4);
        chk("sat_cnt", 32'(ovf_cnt), 255);
        chk("sat_flag", 32'(ovf_flag), 32'hF);
        repeat (2) begin
            in_lvl = ~in_lvl;
            step(1);
        end
        step(4);
        chk("sat_hold", 32'(ovf_cnt), 255);
        // a drop in the same cycle as a clear wins
        in_lvl[0] = ~in_lvl[0];
        step(2);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("clrdrop_flag", 32'(ovf_flag), 32'h1);
        chk("clrdrop_cnt", 32'(ovf_cnt), 1);
        ovf_clr = 1'b1;
        step(1);
        ovf_clr = 1'b0;
        chk("clr2_flag", 32'(ovf_flag), 0);
        chk("clr2_cnt", 32'(ovf_cnt), 0);
        // reset in PRESENT discards everything immediately
        chk("pre_rst_valid", 32'(evt_valid), 1);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(evt_valid), 0);
        chk("arst_id", 32'(evt_id), 0);
        chk("arst_rise", 32'(evt_rise), 0);
        chk("arst_flag", 32'(ovf_flag), 0);
        chk("arst_cnt", 32'(ovf_cnt), 0);
        in_lvl = '0; fall_en = '0; evt_ready = 1'b1;
        step(2);
        rst_n = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step(1);
            chk("post_rst_idle", 32'(evt_valid), 0);
        end
        // levels high at reset release give exactly one rise each
        rst_n = 1'b0;
        in_lvl = 4'b1010;
        step(2);
        sb.push_back({2'd1, 1'b1});
        sb.push_back({2'd3, 1'b1});
        rst_n = 1'b1;
        step(15);
        chk("rel_drained", 32'(sb.size()), 0);
        chk("rel_cnt", 32'(ovf_cnt), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/edge_event_arbiter.md
EDGE_EVENT_ARBITER -- requirements
Module: edge_event_arbiter

Interface
REQ-001 Parameter N, default 4, number of monitored input channels (2..16).
REQ-002 Parameter CNT_W, default 8, width of the overflow counter.
REQ-003 Parameter ID_W, default $clog2(N), width of the event channel ID.
REQ-004 clk  input  1  single clock; all state SHALL change only on its rising edge, except on reset.
REQ-005 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 in_lvl  input  N  asynchronous level inputs, one per channel.
REQ-007 cfg_rise_en  input  N  per-channel enable for rising-edge events.
REQ-008 cfg_fall_en  input  N  per-channel enable for falling-edge events.
REQ-009 evt_valid  output  1  event presented on the output channel.
REQ-010 evt_ready  input  1  consumer accepts the event when high with evt_valid.
REQ-011 evt_id  output  ID_W  channel index of the presented event.
REQ-012 evt_rise  output  1  1 = rising edge, 0 = falling edge.
REQ-013 ovf_flag  output  N  sticky per-channel overflow indication.
REQ-014 ovf_cnt  output  CNT_W  saturating count of dropped events, all channels.
REQ-015 ovf_clr  input  1  synchronous clear of ovf_flag and ovf_cnt.

Function
REQ-016 Each in_lvl bit SHALL pass through a 2-flop synchronizer (s1, s2), then a history flop (s3); edge detection SHALL compare s2 against s3.
REQ-017 A rise (s2 & ~s3) with cfg_rise_en[i] = 1, or a fall (~s2 & s3) with cfg_fall_en[i] = 1, SHALL form a qualified event on channel i.
REQ-018 Each channel SHALL hold one pending slot (pend[i], pend_rise[i]); a qualified event SHALL set pend[i] and record its type on the next edge.
REQ-019 A qualified event arriving while pend[i] = 1 and the slot is not being granted in the same cycle SHALL be dropped: ovf_flag[i] set, ovf_cnt +1, and the pending type left unchanged.
REQ-020 A qualified event arriving in the same cycle as channel i is granted SHALL be stored as the new pending event, with no overflow.
REQ-021 ovf_cnt SHALL saturate at 2^CNT_W-1; multiple simultaneous drops in one cycle SHALL add their count, still saturating.
REQ-022 ovf_clr SHALL zero ovf_flag and ovf_cnt; a drop in the same cycle SHALL take priority, leaving flag = 1 and cnt = 1 for that drop.
REQ-023 FSM states: IDLE, PRESENT.
REQ-024 IDLE: if any pend = 1, grant the first pending channel searching from last_grant+1 modulo N; load evt_id/evt_rise; clear that pend; set last_grant; go to PRESENT. Otherwise stay in IDLE.
REQ-025 PRESENT: evt_valid = 1; evt_id and evt_rise SHALL stay stable until evt_valid & evt_ready; on accept, go to IDLE and drop evt_valid on the next edge.
REQ-026 Maximum throughput SHALL be one event per 2 cycles; evt_valid SHALL be 0 in IDLE.
REQ-027 Latency: an in_lvl change sampled at edge E0 SHALL give evt_valid = 1 after edge E3 when the arbiter is idle and no other channel is pending.
REQ-028 Changing cfg_*_en SHALL affect only future detections; already pending events SHALL still be delivered.
REQ-029 Under continuous requests on all channels, each channel SHALL be granted at least once in every N grants.

Reset
REQ-030 On rst_n low, all of the following SHALL clear asynchronously: s1/s2/s3, pend, pend_rise, evt_valid, evt_id, evt_rise, ovf_flag and ovf_cnt; FSM = IDLE; last_grant = N-1.
REQ-031 An in_lvl bit high at reset release SHALL produce exactly one rise event if enabled.
REQ-032 Reset asserted in PRESENT SHALL discard the presented event and all pending events, with no overflow counted.

Verification
REQ-033 Pulse in_lvl[2] 0->1, rise_en = all ones, evt_ready = 1 -> evt_valid after E3, evt_id = 2, evt_rise = 1, single-cycle valid.
REQ-034 Simultaneous rises on channels 0, 1 and 3 after reset, evt_ready = 1 -> grants in order 0, 1, 3, one every 2 cycles.
REQ-035 evt_ready held 0 for 10 cycles while channel 1 toggles 3 times (rise and fall enabled) -> evt_id/evt_rise stable; ovf_flag[1] = 1, ovf_cnt = 1, one pending event kept.
REQ-036 Drive ovf_cnt to 255 (CNT_W = 8), then cause another drop -> ovf_cnt stays 255; ovf_clr -> 0.
REQ-037 in_lvl = 4'b1010 at reset release, rise_en = 4'hF -> exactly two events, ids 1 then 3.
REQ-038 rst_n pulsed low during PRESENT -> evt_valid = 0 immediately; all outputs zero; no event delivered after release.
